// File: rtl/outbuf_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// outbuf_fifo_ctrl
//
// Output-buffer controller and FIFO for the PE array's partial-sum write-back
// path. A `done` pulse in IDLE starts a job of `job_len` words. In FETCH the
// block requests words from the scratchpad while the FIFO has room, and stores
// each accepted word. Draining runs continuously over a valid/ready port.
// `psum_done` pulses for one cycle once every word of the job has been
// captured. The FIFO may still hold data at that point.
//
// Optional feature (macro OUTBUF_RELU_EN):
//   defined   : each lane is rectified at push (negative lane stored as 0)
//   undefined : words are stored verbatim
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   done, job_len      job start pulse and length (sampled in IDLE only)
//   rd_req             scratchpad may present a word this cycle
//   read_from_scratch  scratchpad word strobe
//   scratch_data       scratchpad word, lane i = [i*DATA_W +: DATA_W]
//   stall_pipeline     FETCH with FIFO full
//   out_valid/out_ready/out_data  downstream port (show-ahead FIFO head)
//   fifo_count         current occupancy
//   overflow           sticky: a strobe arrived in FETCH while rd_req was low
//   psum_done          one-cycle pulse, job capture complete
//
// Handshakes: a transfer happens on a rising edge where both sides are high.
// Upstream: rd_req && read_from_scratch. Downstream: out_valid && out_ready.
// rd_req and out_valid depend only on registers, never on the partner's input.
// -----------------------------------------------------------------------------
module outbuf_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       done,
    input  logic [LEN_W-1:0]           job_len,
    output logic                       rd_req,
    input  logic                       read_from_scratch,
    input  logic [NUM_CH*DATA_W-1:0]   scratch_data,
    output logic                       stall_pipeline,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       psum_done
);

    localparam int WORD_W = NUM_CH * DATA_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // One-hot state encoding
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_FETCH = 3'b010;
    localparam logic [2:0] ST_DONE  = 3'b100;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              in_fetch;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] push_data;

    // Handshake qualifiers. rd_req uses the registered count only, so a pop
    // in the same cycle never opens a slot for a push (no bypass when full).
    always_comb begin
        in_fetch = (state_q == ST_FETCH);
        rd_req   = in_fetch && (count_q < FULL_COUNT);
        push     = rd_req && read_from_scratch;
        pop      = (count_q != '0) && out_ready;
    end

    // Write-side data path
`ifdef OUTBUF_RELU_EN
    always_comb begin
        push_data = scratch_data;
        for (int i = 0; i < NUM_CH; i++) begin
            if (scratch_data[i*DATA_W + DATA_W - 1]) begin
                push_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end
`else
    always_comb begin
        push_data = scratch_data;
    end
`endif

    // FSM, counters and sticky flag
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        // Strobes outside FETCH are ignored and never flag overflow
        overflow_d  = overflow_q || (in_fetch && read_from_scratch && !rd_req);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    if (job_len != '0) begin
                        remaining_d = job_len;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (push) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the zero count hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Outputs
    always_comb begin
        out_valid      = (count_q != '0);
        out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
        fifo_count     = count_q;
        stall_pipeline = in_fetch && (count_q == FULL_COUNT);
        overflow       = overflow_q;
        psum_done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_outbuf_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_outbuf_fifo_ctrl
//
// Bench for outbuf_fifo_ctrl with default parameters. A reference model runs
// on the falling edge: it checks every output against its own view of state,
// FIFO contents (the expected queue) and overflow, then advances using the
// inputs that the next rising edge will sample. Directed sequences add
// explicit checks at the points of interest.
// -----------------------------------------------------------------------------
module tb_outbuf_fifo_ctrl;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 8;
    localparam int W      = NUM_CH * DATA_W;
    localparam int CW     = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             done = 1'b0;
    logic [LEN_W-1:0] job_len = '0;
    logic             rd_req;
    logic             read_from_scratch = 1'b0;
    logic [W-1:0]     scratch_data = '0;
    logic             stall_pipeline;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic             psum_done;

    always #5 clk = ~clk;

    outbuf_fifo_ctrl #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .job_len(job_len),
        .rd_req(rd_req), .read_from_scratch(read_from_scratch),
        .scratch_data(scratch_data), .stall_pipeline(stall_pipeline),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count), .overflow(overflow), .psum_done(psum_done)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] relu_model(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef OUTBUF_RELU_EN
        for (int i = 0; i < NUM_CH; i++) begin
            if (w[i*DATA_W + DATA_W - 1]) r[i*DATA_W +: DATA_W] = '0;
        end
`endif
        return r;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    localparam int M_IDLE = 0, M_FETCH = 1, M_DONE = 2;
    logic [W-1:0] exp_q[$];
    int           m_state = M_IDLE;
    int           m_rem   = 0;
    bit           m_ovf   = 1'b0;
    int           max_cnt = 0;
    bit           mon_en  = 1'b1;
    int           m_cnt;
    bit           m_rreq, m_acc;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                m_state = M_IDLE; m_rem = 0; m_ovf = 1'b0;
                exp_q.delete();
                check("rst_rd_req",    64'(rd_req),     64'(0));
                check("rst_out_valid", 64'(out_valid),  64'(0));
                check("rst_count",     64'(fifo_count), 64'(0));
                check("rst_psum_done", 64'(psum_done),  64'(0));
            end else begin
                m_cnt  = exp_q.size();
                m_rreq = (m_state == M_FETCH) && (m_cnt < DEPTH);
                if (m_cnt > max_cnt) max_cnt = m_cnt;
                check("mon_rd_req",    64'(rd_req),         64'(m_rreq));
                check("mon_stall",     64'(stall_pipeline), 64'((m_state == M_FETCH) && (m_cnt == DEPTH)));
                check("mon_out_valid", 64'(out_valid),      64'(m_cnt != 0));
                check("mon_count",     64'(fifo_count),     64'(m_cnt));
                check("mon_overflow",  64'(overflow),       64'(m_ovf));
                check("mon_psum_done", 64'(psum_done),      64'(m_state == M_DONE));
                if (m_cnt != 0) check("mon_out_data", out_data, exp_q[0]);
                else            check("mon_out_data_zero", out_data, '0);

                // advance model with inputs sampled by the coming rising edge
                m_acc = m_rreq && read_from_scratch;
                if ((m_state == M_FETCH) && read_from_scratch && !m_rreq) m_ovf = 1'b1;
                if ((m_cnt != 0) && out_ready) void'(exp_q.pop_front());
                if (m_acc) exp_q.push_back(relu_model(scratch_data));
                case (m_state)
                    M_IDLE: if (done) begin
                        if (job_len != '0) begin m_rem = int'(job_len); m_state = M_FETCH; end
                        else m_state = M_DONE;
                    end
                    M_FETCH: if (m_acc) begin
                        if (m_rem == 1) m_state = M_DONE;
                        m_rem--;
                    end
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        read_from_scratch = 1'b0; done = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_job(input int len);
        done = 1'b1;
        job_len = LEN_W'(len);
        step();
        done = 1'b0;
    endtask

    // Strobe a word whenever rd_req is high until n words are accepted.
    task automatic feed(input int n, input logic [W-1:0] base, input bit rnd_data, input bit rnd_ready);
        int got;
        got = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (rd_req) begin
                read_from_scratch = 1'b1;
                scratch_data = rnd_data ? {$urandom(), $urandom()} : base + W'(got);
                got++;
            end else begin
                read_from_scratch = 1'b0;
            end
            step();
        end
        read_from_scratch = 1'b0;
        check("feed_accepts", 64'(got), 64'(n));
    endtask

    task automatic drain(input bit rnd_ready);
        int c;
        c = 0;
        while (out_valid && c < 300) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            c++;
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'(0));
        check("drain_sb_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_rd_req",   64'(rd_req),     64'(0));
        check("reset_out_data", out_data,        '0);
        check("reset_overflow", 64'(overflow),   64'(0));
        check("reset_count",    64'(fifo_count), 64'(0));

        // Reset mid-job with three words held
        out_ready = 1'b0;
        start_job(6);
        feed(3, 64'h0000_0000_0000_0100, 1'b0, 1'b0);
        check("midjob_count", 64'(fifo_count), 64'(3));
        #1 rst_n = 1'b0;
        #1;
        check("async_rd_req",    64'(rd_req),         64'(0));
        check("async_stall",     64'(stall_pipeline), 64'(0));
        check("async_out_valid", 64'(out_valid),      64'(0));
        check("async_psum_done", 64'(psum_done),      64'(0));
        check("async_overflow",  64'(overflow),       64'(0));
        check("async_out_data",  out_data,            '0);
        check("async_count",     64'(fifo_count),     64'(0));
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_rd_req",    64'(rd_req),    64'(0));

        // Basic job
        out_ready = 1'b1;
        start_job(4);
        check("basic_rd_req_after_done", 64'(rd_req), 64'(1));
        feed(4, 64'h0001_0002_0003_0004, 1'b0, 1'b0);
        check("basic_psum_done", 64'(psum_done), 64'(1));
        check("basic_overflow",  64'(overflow),  64'(0));
        step();
        check("basic_psum_done_drop", 64'(psum_done), 64'(0));
        drain(1'b0);

        // Full / stall / overflow
        out_ready = 1'b0;
        start_job(10);
        feed(8, 64'h0000_0000_0000_1000, 1'b0, 1'b0);
        check("full_rd_req", 64'(rd_req),         64'(0));
        check("full_stall",  64'(stall_pipeline), 64'(1));
        check("full_count",  64'(fifo_count),     64'(DEPTH));
        read_from_scratch = 1'b1;
        scratch_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        read_from_scratch = 1'b0;
        check("full_overflow_set", 64'(overflow),   64'(1));
        check("full_drop_count",   64'(fifo_count), 64'(DEPTH));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_pop_rd_req", 64'(rd_req),     64'(1));
        check("full_pop_count",  64'(fifo_count), 64'(DEPTH - 1));
        out_ready = 1'b1;
        feed(2, 64'h0000_0000_0000_1008, 1'b0, 1'b0);
        check("full_psum_done", 64'(psum_done), 64'(1));
        drain(1'b0);
        check("full_overflow_sticky", 64'(overflow), 64'(1));
        apply_reset();

        // Wrap with random backpressure and random data
        max_cnt = 0;
        start_job(20);
        feed(20, '0, 1'b1, 1'b1);
        check("wrap_psum_done", 64'(psum_done), 64'(1));
        drain(1'b1);
        check("wrap_max_le_depth", 64'(max_cnt <= DEPTH), 64'(1));
        check("wrap_overflow", 64'(overflow), 64'(0));

        // Ignored strobe in IDLE, zero length, ignored start during FETCH
        read_from_scratch = 1'b1;
        scratch_data = 64'h1111_2222_3333_4444;
        step();
        read_from_scratch = 1'b0;
        check("idle_strobe_overflow", 64'(overflow),   64'(0));
        check("idle_strobe_count",    64'(fifo_count), 64'(0));
        start_job(0);
        check("zero_psum_done", 64'(psum_done), 64'(1));
        check("zero_rd_req",    64'(rd_req),    64'(0));
        step();
        check("zero_psum_done_drop", 64'(psum_done), 64'(0));
        out_ready = 1'b1;
        start_job(5);
        feed(2, 64'h0000_0000_0000_2000, 1'b0, 1'b0);
        done = 1'b1;
        job_len = LEN_W'(2);
        step();
        done = 1'b0;
        feed(3, 64'h0000_0000_0000_2002, 1'b0, 1'b0);
        check("ignored_start_psum_done", 64'(psum_done), 64'(1));
        drain(1'b0);

        // ReLU lanes
        out_ready = 1'b0;
        start_job(1);
        feed(1, 64'hFFFF_7FFF_8000_0005, 1'b0, 1'b0);
        check("relu_valid", 64'(out_valid), 64'(1));
`ifdef OUTBUF_RELU_EN
        check("relu_data", out_data, 64'h0000_7FFF_0000_0005);
`else
        check("relu_data", out_data, 64'hFFFF_7FFF_8000_0005);
`endif
        drain(1'b0);

        step();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/outbuf_fifo_ctrl.md
# outbuf_fifo_ctrl

Parametrised output-buffer controller and FIFO for the PE array's partial-sum write-back path. After `done`, it fetches a programmable number of multi-channel psum words from the scratchpad and stores them in an internal FIFO. It stalls the pipeline while the FIFO is full, drains words downstream over a valid/ready port, and pulses `psum_done` once the whole job is captured. It supersedes the single-word outbuf FSM: it adds configurable width, channel count, FIFO depth and burst length, plus overflow detection.

## Interface
- `DATA_W`, 16, bit width of one channel psum (signed two's complement)
- `NUM_CH`, 4, channels packed per word
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `LEN_W`, 8, width of job length
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset; one clock; reset is asynchronous and active-low
- `done` in 1, start pulse from PE; sampled only in IDLE
- `job_len` in LEN_W, words to fetch; latched with `done`
- `rd_req` out 1, scratchpad may present a word this cycle
- `read_from_scratch` in 1, scratchpad word valid
- `scratch_data` in NUM_CH*DATA_W, lane i = bits [i*DATA_W +: DATA_W]
- `stall_pipeline` out 1, high in FETCH while FIFO full
- `out_valid` out 1, FIFO non-empty
- `out_ready` in 1, downstream accepts head word
- `out_data` out NUM_CH*DATA_W, FIFO head; 0 when `out_valid`=0
- `fifo_count` out $clog2(DEPTH)+1, current occupancy
- `overflow` out 1, sticky: a strobe was dropped
- `psum_done` out 1, one-cycle pulse; all job words accepted

## Operation
- **States:** IDLE, FETCH, DONE (one-hot).
- **IDLE:**
  - `done`=1 with `job_len`≠0: latch `remaining`=`job_len`, go to FETCH.
  - `done`=1 with `job_len`=0: go directly to DONE.
- **FETCH:**
  - `rd_req` = (`fifo_count` < DEPTH), combinational from registers.
  - Accept = `rd_req` && `read_from_scratch`. On accept: push word, `remaining`--.
  - Accept with `remaining`=1: go to DONE.
  - `read_from_scratch`=1 while `rd_req`=0: word dropped, `overflow` set.
- **DONE:** `psum_done`=1 for exactly one cycle, then IDLE.
- **Ignored inputs:**
  - `done` outside IDLE.
  - `read_from_scratch` outside FETCH; does not set `overflow`.
- **FIFO:**
  - Show-ahead: `out_data` = mem[rd_ptr].
  - Pop = `out_valid` && `out_ready`.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: no bypass. A pop in the same cycle does not enable a push; `rd_req` stays low that cycle.
  - Draining continues in every state, independent of the FSM.
- **`overflow`:** cleared only by reset.
- **`psum_done`:** means capture is complete. The FIFO may still hold data.

## Timing
- **Reset values:** state IDLE, pointers/count 0, `remaining` 0. Outputs: `rd_req`, `stall_pipeline`, `out_valid`, `psum_done`, `overflow` all 0; `out_data` 0; `fifo_count` 0.
- **Reset mid-job:** abandons the job and empties the FIFO immediately (asynchronous).
- **Latency:**
  - `done` at edge N → FETCH, `rd_req` high in cycle N+1 (if not full).
  - Word accepted at edge M → `out_valid`/`out_data` visible in cycle M+1.
  - Last accept at edge M → `psum_done` high in cycle M+1.
- **Throughput:** one word per cycle in and out.
- `stall_pipeline` = FETCH && `fifo_count`==DEPTH.
- Pop at the edge ending a full cycle → `rd_req` high the next cycle.

## Configuration
- **`OUTBUF_RELU_EN` defined:** each lane is rectified at push. A negative lane (MSB=1) is stored as 0; non-negative lanes are stored unchanged.
- **`OUTBUF_RELU_EN` undefined:** words are stored verbatim; no rectification logic is present.

## Test plan
- **Reset:** `rst_n`=0 mid-FETCH with `fifo_count`=3 → all outputs 0 asynchronously. After release: IDLE, `out_valid`=0.
- **Basic job:** `job_len`=4, `out_ready`=1, strobes every cycle, data 0x0001_0002_0003_0004+k → 4 words out in order, each one cycle after accept. `psum_done` one cycle after the 4th accept. `overflow`=0.
- **Full/stall:** DEPTH=8, `job_len`=10, `out_ready`=0 → after 8 accepts: `rd_req`=0, `stall_pipeline`=1. A strobe then sets `overflow`=1 and the word is dropped. Raise `out_ready` → 1 pop, `rd_req` high next cycle, job completes.
- **Wrap:** 20 words through DEPTH=8 with random `out_ready` → output sequence identical to input. `fifo_count` never exceeds 8.
- **Zero length and ignored start:** `job_len`=0 → `psum_done` in the cycle after `done`, no `rd_req`. `done` pulsed during FETCH → no effect on `remaining`.
- **ReLU:** with `OUTBUF_RELU_EN`, input lanes {0xFFFF, 0x7FFF, 0x8000, 0x0005} → output {0x0000, 0x7FFF, 0x0000, 0x0005}. Without the macro → output equals input.
